// File: rtl/sp_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_burst_ctrl
// Brief    : Initiator-side burst controller moving valid/ready beats to/from sp_ram.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE  = 1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]  r_beats_left;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic w_last_beat;
    logic w_rd_load;

    assign w_last_beat = (r_beats_left == c_LEN_ONE);
    // The output register refills whenever it is empty or being consumed this cycle.
    assign w_rd_load   = !r_rd_valid || rd_ready;

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign wr_ready  = (r_state == WRITE);
    // rst_n gates the strobe so a write beat coinciding with reset never lands.
    assign ram_en    = wr_valid && rst_n && (r_state == WRITE);
    assign ram_addr  = r_cur_addr;
    assign ram_din   = wr_data;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr   <= cmd_addr;
                        r_beats_left <= cmd_len;
                        if (cmd_len == '0) begin
                            r_state <= DONE;
                        end else if (cmd_write) begin
                            r_state <= WRITE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        r_cur_addr   <= r_cur_addr + c_ADDR_ONE;
                        r_beats_left <= r_beats_left - c_LEN_ONE;
                        if (w_last_beat) begin
                            r_state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (w_rd_load) begin
                        r_rd_data    <= ram_dout;
                        r_rd_valid   <= 1'b1;
                        r_cur_addr   <= r_cur_addr + c_ADDR_ONE;
                        r_beats_left <= r_beats_left - c_LEN_ONE;
                        if (w_last_beat) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_burst_ctrl
// Brief    : Self-checking bench for sp_ram_burst_ctrl against an array-based memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_burst_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LW    = 5;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, ram_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready, rd_valid, rd_ready, busy, done, ram_en;
    logic [DW-1:0] wr_data, rd_data, ram_din, ram_dout;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    int            wcyc_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            rcyc_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] src_q[$];
    int            done_cyc, en_cnt, first_rv, stall_viol, busy_low, wrr_cnt;
    logic          extra_done, idle_after;

    sp_ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural sp_ram: synchronous write, combinational read.
    always @(posedge clk) if (ram_en) ram[ram_addr] <= ram_din;
    assign ram_dout = ram[ram_addr];

    task automatic clear_obs();
        wcyc_q.delete(); wa_q.delete(); wd_q.delete(); rcyc_q.delete(); rd_q.delete();
        done_cyc = -1; en_cnt = 0; first_rv = -1; stall_viol = 0; busy_low = 0; wrr_cnt = 0;
        extra_done = 1'b0; idle_after = 1'b0;
    endtask

    // Returns just after the accepting edge; the next negedge is cycle T+1.
    task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
    endtask

    task automatic drive_write(input bit stall);
        clear_obs();
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            wr_valid = (src_q.size() > 0) ? (stall ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            wr_data  = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
            rd_ready = 1'($urandom);
            #1;
            if (ram_en) begin wcyc_q.push_back(c); wa_q.push_back(ram_addr); wd_q.push_back(ram_din); end
            if (!busy) busy_low++;
            if (rd_valid && first_rv < 0) first_rv = c;
            if (wr_valid && wr_ready) void'(src_q.pop_front());
            if (done) begin done_cyc = c; break; end
        end
        @(negedge clk); wr_valid = 1'b0; rd_ready = 1'b0; #1;
        extra_done = done; idle_after = cmd_ready && !busy;
    endtask

    task automatic drive_read(input int mode);
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        clear_obs();
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 3) == 1) : 1'($urandom);
            wr_valid = 1'($urandom); wr_data = DW'($urandom);
            #1;
            if (ram_en) en_cnt++;
            if (wr_ready) wrr_cnt++;
            if (!busy) busy_low++;
            if (rd_valid && first_rv < 0) first_rv = c;
            if (prev_stall && (!rd_valid || rd_data !== prev_data)) stall_viol++;
            prev_stall = rd_valid && !rd_ready; prev_data = rd_data;
            if (rd_valid && rd_ready) begin rcyc_q.push_back(c); rd_q.push_back(rd_data); end
            if (done) begin done_cyc = c; break; end
        end
        @(negedge clk); wr_valid = 1'b0; rd_ready = 1'b0; #1;
        extra_done = done; idle_after = cmd_ready && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b1; wr_data = 8'h5A; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        checks++; if (ram_addr !== 4'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL idle_ignores_wr_valid ram_en got %b want 0", ram_en); end
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_write_basic();
        logic [DW-1:0] d [4];
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int k = 0; k < 4; k++) src_q.push_back(d[k]);
        issue_cmd(1'b1, 4'd2, 5'd4);
        drive_write(1'b0);
        checks++; if (wcyc_q.size() != 4) begin errors++; $display("FAIL wr_basic_count got %0d want 4", wcyc_q.size()); end
        for (int k = 0; k < 4 && k < wcyc_q.size(); k++) begin
            checks++;
            if (wcyc_q[k] != k + 1 || wa_q[k] !== AW'(2 + k) || wd_q[k] !== d[k]) begin
                errors++;
                $display("FAIL wr_basic_beat%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         k, wcyc_q[k], wa_q[k], wd_q[k], k + 1, 2 + k, d[k]);
            end
        end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL wr_basic_done_cycle got %0d want 5", done_cyc); end
        checks++; if (extra_done || !idle_after || busy_low != 0) begin errors++;
            $display("FAIL wr_basic_done_pulse got extra %b idle %b busy_low %0d want 0 1 0", extra_done, idle_after, busy_low); end
        for (int k = 0; k < 4; k++) ref_mem[2 + k] = d[k];
        for (int k = 0; k < 4; k++) begin
            checks++; if (ram[2 + k] !== d[k]) begin errors++; $display("FAIL wr_basic_mem%0d got %h want %h", 2 + k, ram[2 + k], d[k]); end
        end
    endtask

    task automatic test_read_basic();
        issue_cmd(1'b0, 4'd2, 5'd4);
        drive_read(0);
        checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL rd_basic_count got %0d want 4", rd_q.size()); end
        for (int k = 0; k < 4 && k < rd_q.size(); k++) begin
            checks++;
            if (rcyc_q[k] != k + 2 || rd_q[k] !== ref_mem[2 + k]) begin errors++;
                $display("FAIL rd_basic_beat%0d got cyc %0d data %h want cyc %0d data %h", k, rcyc_q[k], rd_q[k], k + 2, ref_mem[2 + k]); end
        end
        checks++; if (first_rv != 2) begin errors++; $display("FAIL rd_basic_first_valid got %0d want 2", first_rv); end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL rd_basic_done_cycle got %0d want 6", done_cyc); end
        checks++; if (en_cnt != 0 || wrr_cnt != 0) begin errors++; $display("FAIL rd_basic_no_write got ram_en %0d wr_ready %0d want 0 0", en_cnt, wrr_cnt); end
        checks++; if (extra_done || !idle_after) begin errors++; $display("FAIL rd_basic_done_pulse got extra %b idle %b want 0 1", extra_done, idle_after); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d [3];
        for (int k = 0; k < 3; k++) begin d[k] = DW'($urandom); src_q.push_back(d[k]); end
        issue_cmd(1'b1, 4'd14, 5'd3);
        drive_write(1'b1);
        checks++; if (wa_q.size() != 3) begin errors++; $display("FAIL wrap_count got %0d want 3", wa_q.size()); end
        for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== AW'((14 + k) % DEPTH) || wd_q[k] !== d[k]) begin errors++;
                $display("FAIL wrap_beat%0d got addr %0d data %h want addr %0d data %h", k, wa_q[k], wd_q[k], (14 + k) % DEPTH, d[k]); end
        end
        if (wcyc_q.size() == 3) begin
            checks++; if (done_cyc != wcyc_q[2] + 1) begin errors++; $display("FAIL wrap_done got %0d want %0d", done_cyc, wcyc_q[2] + 1); end
        end
        for (int k = 0; k < 3; k++) ref_mem[(14 + k) % DEPTH] = d[k];
        issue_cmd(1'b0, 4'd14, 5'd3);
        drive_read(2);
        checks++; if (rd_q.size() != 3) begin errors++; $display("FAIL wrap_rd_count got %0d want 3", rd_q.size()); end
        for (int k = 0; k < 3 && k < rd_q.size(); k++) begin
            checks++; if (rd_q[k] !== d[k]) begin errors++; $display("FAIL wrap_rd_beat%0d got %h want %h", k, rd_q[k], d[k]); end
        end
    endtask

    task automatic test_read_stall();
        logic [AW-1:0] a;
        a = AW'($urandom);
        issue_cmd(1'b0, a, 5'd4);
        drive_read(1);
        checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", rd_q.size()); end
        for (int k = 0; k < 4 && k < rd_q.size(); k++) begin
            checks++; if (rd_q[k] !== ref_mem[(a + k) % DEPTH]) begin errors++;
                $display("FAIL stall_beat%0d got %h want %h", k, rd_q[k], ref_mem[(a + k) % DEPTH]); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold got %0d violations want 0", stall_viol); end
        checks++; if (first_rv != 2) begin errors++; $display("FAIL stall_first_valid got %0d want 2", first_rv); end
        if (rcyc_q.size() == 4) begin
            checks++; if (done_cyc != rcyc_q[3] + 1) begin errors++; $display("FAIL stall_done got %0d want %0d", done_cyc, rcyc_q[3] + 1); end
        end
    endtask

    task automatic test_empty();
        for (int w = 1; w >= 0; w--) begin
            issue_cmd(1'(w), AW'($urandom), 5'd0);
            @(negedge clk); wr_valid = 1'b1; rd_ready = 1'b1; #1;
            checks++; if (done !== 1'b1 || ram_en !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++;
                $display("FAIL empty%0d_t1 got done %b en %b rv %b cr %b want 1 0 0 0", w, done, ram_en, rd_valid, cmd_ready); end
            @(negedge clk); #1;
            checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || ram_en !== 1'b0 || rd_valid !== 1'b0) begin errors++;
                $display("FAIL empty%0d_t2 got done %b cr %b en %b rv %b want 0 1 0 0", w, done, cmd_ready, ram_en, rd_valid); end
            wr_valid = 1'b0; rd_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midburst();
        logic [AW-1:0] a;
        logic [DW-1:0] d [8];
        int            bad;
        a = AW'($urandom);
        for (int k = 0; k < 8; k++) d[k] = ~ref_mem[(a + k) % DEPTH];
        issue_cmd(1'b1, a, 5'd8);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = d[c - 1];
            if (c == 3) rst_n = 1'b0;
            #1;
            checks++; if (ram_en !== (c < 3)) begin errors++; $display("FAIL rstmid_en_c%0d got %b want %b", c, ram_en, c < 3); end
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || ram_en !== 1'b0) begin errors++;
            $display("FAIL rstmid_idle got busy %b cr %b done %b en %b want 0 1 0 0", busy, cmd_ready, done, ram_en); end
        @(negedge clk); wr_valid = 1'b0; #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b want 0", done); end
        ref_mem[a] = d[0];
        ref_mem[(a + 1) % DEPTH] = d[1];
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (ram[k] !== ref_mem[k]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_mem got %0d differing words want 0", bad); end
        issue_cmd(1'b0, a, 5'd8);
        drive_read(0);
        checks++; if (rd_q.size() != 8 || done_cyc != 10) begin errors++;
            $display("FAIL rstmid_after got beats %0d done %0d want 8 10", rd_q.size(), done_cyc); end
        for (int k = 0; k < 8 && k < rd_q.size(); k++) begin
            checks++; if (rd_q[k] !== ref_mem[(a + k) % DEPTH]) begin errors++;
                $display("FAIL rstmid_rd%0d got %h want %h", k, rd_q[k], ref_mem[(a + k) % DEPTH]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic          op;
            logic [AW-1:0] a;
            int            len, mode, exp_done;
            logic [DW-1:0] d[$];
            op = 1'($urandom); a = AW'($urandom); len = $urandom_range(0, DEPTH);
            d.delete();
            if (op) begin
                for (int k = 0; k < len; k++) begin d.push_back(DW'($urandom)); src_q.push_back(d[k]); end
                issue_cmd(1'b1, a, LW'(len));
                drive_write(1'b1);
                checks++; if (wa_q.size() != len) begin errors++; $display("FAIL rnd%0d_wr_count got %0d want %0d", it, wa_q.size(), len); end
                for (int k = 0; k < len && k < wa_q.size(); k++) begin
                    checks++;
                    if (wa_q[k] !== AW'((a + k) % DEPTH) || wd_q[k] !== d[k]) begin errors++;
                        $display("FAIL rnd%0d_wr_beat%0d got addr %0d data %h want addr %0d data %h", it, k, wa_q[k], wd_q[k], (a + k) % DEPTH, d[k]); end
                end
                exp_done = (len == 0) ? 1 : ((wcyc_q.size() > 0) ? wcyc_q[wcyc_q.size() - 1] + 1 : -2);
                for (int k = 0; k < len; k++) ref_mem[(a + k) % DEPTH] = d[k];
                src_q.delete();
            end else begin
                mode = $urandom_range(0, 2);
                issue_cmd(1'b0, a, LW'(len));
                drive_read(mode);
                checks++; if (rd_q.size() != len) begin errors++; $display("FAIL rnd%0d_rd_count got %0d want %0d", it, rd_q.size(), len); end
                for (int k = 0; k < len && k < rd_q.size(); k++) begin
                    checks++; if (rd_q[k] !== ref_mem[(a + k) % DEPTH]) begin errors++;
                        $display("FAIL rnd%0d_rd_beat%0d got %h want %h", it, k, rd_q[k], ref_mem[(a + k) % DEPTH]); end
                end
                checks++; if (stall_viol != 0 || en_cnt != 0) begin errors++;
                    $display("FAIL rnd%0d_rd_rules got stall_viol %0d ram_en %0d want 0 0", it, stall_viol, en_cnt); end
                exp_done = (len == 0) ? 1 : ((rcyc_q.size() > 0) ? rcyc_q[rcyc_q.size() - 1] + 1 : -2);
            end
            checks++; if (done_cyc != exp_done || extra_done || !idle_after) begin errors++;
                $display("FAIL rnd%0d_done got cyc %0d extra %b idle %b want cyc %0d 0 1", it, done_cyc, extra_done, idle_after, exp_done); end
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ram[k]     = DW'($urandom);
            ref_mem[k] = ram[k];
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap();
        test_read_stall();
        test_empty();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
